// File: rtl/winograd_psum_accum_if.sv
// Beat/result bundle between the Winograd PE array, the partial-sum accumulator and the pooling stage.
interface winograd_psum_accum_if #(
  parameter int unsigned RESULT_SIZE = 2,
  parameter int unsigned OUT_BIT     = 24,
  parameter int unsigned X_PE        = 16,
  parameter int unsigned ADDR_BIT    = 10
);
  localparam int unsigned DW = OUT_BIT * X_PE * RESULT_SIZE * RESULT_SIZE;

  logic                start;
  logic [ADDR_BIT:0]   num_tiles;
  logic                relu_en;
  logic                in_valid;
  logic                pass_first;
  logic                pass_last;
  logic [DW-1:0]       in_data;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic [ADDR_BIT-1:0] out_tile;
  logic                ovf_sticky;
  logic                cfg_err;

  modport master (
    output start, num_tiles, relu_en, in_valid, pass_first, pass_last, in_data,
    input  out_valid, out_data, out_tile, ovf_sticky, cfg_err
  );

  modport slave (
    input  start, num_tiles, relu_en, in_valid, pass_first, pass_last, in_data,
    output out_valid, out_data, out_tile, ovf_sticky, cfg_err
  );
endinterface

// File: rtl/winograd_psum_accum.sv
// Per-tile partial-sum accumulator across input-channel passes, with saturation,
// sticky overflow and optional ReLU on the final pass.
module winograd_psum_accum #(
  parameter int unsigned RESULT_SIZE = 2,
  parameter int unsigned OUT_BIT     = 24,
  parameter int unsigned X_PE        = 16,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_BIT    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  winograd_psum_accum_if.slave  bus
);
  localparam int unsigned LANES = X_PE * RESULT_SIZE * RESULT_SIZE;
  localparam int unsigned DW    = OUT_BIT * LANES;
  localparam int unsigned NW    = ADDR_BIT + 1;
  localparam logic [OUT_BIT-1:0] SAT_MAX = {1'b0, {(OUT_BIT-1){1'b1}}};
  localparam logic [OUT_BIT-1:0] SAT_MIN = {1'b1, {(OUT_BIT-1){1'b0}}};

  logic [DW-1:0]       mem_q [DEPTH];
  logic [ADDR_BIT-1:0] tc_q, tc_d;
  logic                s0_valid_q;
  logic                s0_first_q, s0_last_q, s0_relu_q;
  logic [ADDR_BIT-1:0] s0_addr_q;
  logic [DW-1:0]       s0_data_q, rd_q;
  logic                out_valid_q;
  logic [DW-1:0]       out_data_q;
  logic [ADDR_BIT-1:0] out_tile_q;
  logic                ovf_q, ovf_d;

  logic                cfg_err_c, accept_c, wr_en_c, fwd_c, clamp_c;
  logic [ADDR_BIT-1:0] rd_addr_c;
  logic [NW-1:0]       tc_inc_c;
  logic [DW-1:0]       sat_c, res_c;

  assign cfg_err_c = (bus.num_tiles == '0) || (bus.num_tiles > NW'(DEPTH));
  assign accept_c  = bus.in_valid && !cfg_err_c;
  assign rd_addr_c = bus.start ? '0 : tc_q;
  assign tc_inc_c  = NW'(rd_addr_c) + NW'(1);
  assign wr_en_c   = s0_valid_q && !s0_last_q;
  // num_tiles==1 back-to-back: the read must see the value being written this edge
  assign fwd_c     = wr_en_c && (s0_addr_q == rd_addr_c);

  // Tile counter and sticky overflow next-state
  always_comb begin
    tc_d  = tc_q;
    ovf_d = ovf_q;
    if (accept_c) begin
      tc_d = (tc_inc_c >= bus.num_tiles) ? '0 : ADDR_BIT'(tc_inc_c);
    end else if (bus.start) begin
      tc_d = '0;
    end
    if (bus.start) begin
      ovf_d = 1'b0;
    end else if (s0_valid_q && clamp_c) begin
      ovf_d = 1'b1;
    end
  end

  // Per-lane widened add, saturate, then ReLU for the emitted copy only
  always_comb begin : lane_math
    logic [OUT_BIT-1:0] a, b, lane;
    logic [OUT_BIT:0]   sum;
    sat_c   = '0;
    res_c   = '0;
    clamp_c = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      a   = s0_data_q[k*OUT_BIT +: OUT_BIT];
      b   = rd_q[k*OUT_BIT +: OUT_BIT];
      sum = s0_first_q ? {a[OUT_BIT-1], a}
                       : ({a[OUT_BIT-1], a} + {b[OUT_BIT-1], b});
      if (sum[OUT_BIT] != sum[OUT_BIT-1]) begin
        clamp_c = 1'b1;
        lane    = sum[OUT_BIT] ? SAT_MIN : SAT_MAX;
      end else begin
        lane    = sum[OUT_BIT-1:0];
      end
      sat_c[k*OUT_BIT +: OUT_BIT] = lane;
      res_c[k*OUT_BIT +: OUT_BIT] = (s0_relu_q && lane[OUT_BIT-1]) ? '0 : lane;
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      tc_q        <= '0;
      s0_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tile_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      tc_q        <= tc_d;
      s0_valid_q  <= accept_c;
      out_valid_q <= s0_valid_q && s0_last_q;
      ovf_q       <= ovf_d;
      if (s0_valid_q && s0_last_q) begin
        out_data_q <= res_c;
        out_tile_q <= s0_addr_q;
      end
    end
  end

  // Datapath: buffer, S0 capture and synchronous read (contents survive reset)
  always_ff @(posedge clk) begin
    if (accept_c) begin
      s0_data_q  <= bus.in_data;
      s0_first_q <= bus.pass_first;
      s0_last_q  <= bus.pass_last;
      s0_relu_q  <= bus.relu_en;
      s0_addr_q  <= rd_addr_c;
      rd_q       <= fwd_c ? sat_c : mem_q[rd_addr_c];
    end
    if (wr_en_c) begin
      mem_q[s0_addr_q] <= sat_c;
    end
  end

  assign bus.cfg_err    = cfg_err_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_tile   = out_tile_q;
  assign bus.ovf_sticky = ovf_q;
endmodule

// File: tb/tb_winograd_psum_accum.sv
// Directed bench for winograd_psum_accum: multi-pass accumulation, ReLU, forwarding,
// saturation, config errors, mid-stream start and reset.
module tb_winograd_psum_accum;
  localparam int unsigned RS   = 2;
  localparam int unsigned OB   = 24;
  localparam int unsigned XP   = 2;
  localparam int unsigned DEP  = 16;
  localparam int unsigned AB   = 4;
  localparam int unsigned LN   = XP * RS * RS;
  localparam int unsigned DW   = OB * LN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  winograd_psum_accum_if #(.RESULT_SIZE(RS), .OUT_BIT(OB), .X_PE(XP), .ADDR_BIT(AB)) bus ();

  winograd_psum_accum #(.RESULT_SIZE(RS), .OUT_BIT(OB), .X_PE(XP), .DEPTH(DEP), .ADDR_BIT(AB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DW-1:0] fill(input logic [OB-1:0] v);
    logic [DW-1:0] r;
    for (int k = 0; k < LN; k++) r[k*OB +: OB] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] two_lanes(input logic [OB-1:0] v0, input logic [OB-1:0] v1);
    logic [DW-1:0] r;
    r = '0;
    r[0 +: OB]  = v0;
    r[OB +: OB] = v1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic st, input logic f, input logic l, input logic r, input logic [DW-1:0] d);
    bus.start      = st;
    bus.in_valid   = 1'b1;
    bus.pass_first = f;
    bus.pass_last  = l;
    bus.relu_en    = r;
    bus.in_data    = d;
    step();
    bus.start      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.pass_first = 1'b0;
    bus.pass_last  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [AB-1:0] t, input logic [DW-1:0] d);
    chk({tag, "_valid"}, DW'(bus.out_valid), DW'(v));
    if (v) begin
      chk({tag, "_tile"}, DW'(bus.out_tile), DW'(t));
      chk({tag, "_data"}, bus.out_data, d);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0; bus.num_tiles = 5'd4; bus.relu_en = 1'b0; bus.in_valid = 1'b0;
    bus.pass_first = 1'b0; bus.pass_last = 1'b0; bus.in_data = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", DW'(bus.out_valid), DW'(1'b0));
    chk("rst_data",  bus.out_data, '0);
    chk("rst_tile",  DW'(bus.out_tile), DW'(4'd0));
    chk("rst_ovf",   DW'(bus.ovf_sticky), DW'(1'b0));
    chk("rst_cfg",   DW'(bus.cfg_err), DW'(1'b0));

    // 1: three passes of +1 over four tiles, two-edge latency
    bus.num_tiles = 5'd4;
    for (int i = 0; i < 14; i++) begin
      if (i < 12) beat(i == 0, (i / 4) == 0, (i / 4) == 2, 1'b0, fill(24'd1));
      else        step();
      if (i >= 9 && i <= 12) chk_out("t1", 1'b1, AB'(i - 9), fill(24'd3));
      else                   chk("t1_idle_valid", DW'(bus.out_valid), DW'(1'b0));
    end
    chk("t1_ovf", DW'(bus.ovf_sticky), DW'(1'b0));

    // 2: first&last with/without ReLU, and no write-back on first&last
    bus.num_tiles = 5'd2;
    beat(1'b1, 1'b1, 1'b1, 1'b1, fill(24'hFFFFFB));
    beat(1'b0, 1'b1, 1'b1, 1'b0, fill(24'hFFFFFB));
    chk_out("t2_relu", 1'b1, 4'd0, fill(24'd0));
    beat(1'b0, 1'b0, 1'b1, 1'b0, fill(24'd10));
    chk_out("t2_norelu", 1'b1, 4'd1, fill(24'hFFFFFB));
    step();
    chk_out("t2_oldbuf", 1'b1, 4'd0, fill(24'd12));
    step();
    chk("t2_pulse", DW'(bus.out_valid), DW'(1'b0));

    // 3: single tile, back-to-back passes exercise read-after-write forwarding
    bus.num_tiles = 5'd1;
    beat(1'b1, 1'b1, 1'b0, 1'b0, fill(24'd7));
    beat(1'b0, 1'b0, 1'b0, 1'b0, fill(24'd7));
    beat(1'b0, 1'b0, 1'b0, 1'b0, fill(24'd7));
    beat(1'b0, 1'b0, 1'b1, 1'b0, fill(24'd7));
    chk("t3_early_valid", DW'(bus.out_valid), DW'(1'b0));
    step();
    chk_out("t3_fwd", 1'b1, 4'd0, fill(24'd28));

    // 4: positive and negative saturation, sticky flag cleared by start
    beat(1'b1, 1'b1, 1'b0, 1'b0, two_lanes(24'h7FFFF0, 24'h800010));
    beat(1'b0, 1'b0, 1'b1, 1'b0, two_lanes(24'h000020, 24'hFFFFE0));
    chk("t4_ovf_pre", DW'(bus.ovf_sticky), DW'(1'b0));
    step();
    chk_out("t4_sat", 1'b1, 4'd0, two_lanes(24'h7FFFFF, 24'h800000));
    chk("t4_ovf_set", DW'(bus.ovf_sticky), DW'(1'b1));
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t4_ovf_clr", DW'(bus.ovf_sticky), DW'(1'b0));

    // 5: illegal num_tiles blocks beats and holds the tile counter
    bus.num_tiles = 5'd4;
    beat(1'b0, 1'b1, 1'b1, 1'b0, fill(24'd1));
    beat(1'b0, 1'b1, 1'b1, 1'b0, fill(24'd1));
    chk_out("t5_pre0", 1'b1, 4'd0, fill(24'd1));
    bus.num_tiles = 5'd0;
    #1;
    chk("t5_cfg0", DW'(bus.cfg_err), DW'(1'b1));
    beat(1'b0, 1'b1, 1'b1, 1'b0, fill(24'd5));
    chk_out("t5_pre1", 1'b1, 4'd1, fill(24'd1));
    bus.num_tiles = 5'd17;
    #1;
    chk("t5_cfg17", DW'(bus.cfg_err), DW'(1'b1));
    beat(1'b0, 1'b1, 1'b1, 1'b0, fill(24'd5));
    chk("t5_blk0", DW'(bus.out_valid), DW'(1'b0));
    step();
    chk("t5_blk1", DW'(bus.out_valid), DW'(1'b0));
    bus.num_tiles = 5'd16;
    #1;
    chk("t5_cfg16", DW'(bus.cfg_err), DW'(1'b0));
    bus.num_tiles = 5'd4;
    beat(1'b0, 1'b1, 1'b1, 1'b0, fill(24'd9));
    step();
    chk_out("t5_tc_held", 1'b1, 4'd2, fill(24'd9));

    // 6: start mid pass 2 restarts at tile 0; then reset drops an in-flight beat
    bus.num_tiles = 5'd8;
    for (int i = 0; i < 8; i++) beat(i == 0, 1'b1, 1'b0, 1'b0, fill(24'd1));
    for (int i = 0; i < 5; i++) beat(1'b0, 1'b0, 1'b0, 1'b0, fill(24'd1));
    beat(1'b1, 1'b0, 1'b1, 1'b0, fill(24'd10));
    beat(1'b0, 1'b0, 1'b1, 1'b0, fill(24'd0));
    chk_out("t6_restart", 1'b1, 4'd0, fill(24'd12));
    beat(1'b0, 1'b0, 1'b1, 1'b0, fill(24'd0));
    chk_out("t6_tile1", 1'b1, 4'd1, fill(24'd2));
    beat(1'b0, 1'b0, 1'b1, 1'b0, fill(24'd0));
    beat(1'b0, 1'b0, 1'b1, 1'b0, fill(24'd0));
    step();
    chk_out("t6_inflight_wb", 1'b1, 4'd4, fill(24'd2));

    beat(1'b0, 1'b0, 1'b1, 1'b0, fill(24'd3));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_valid", DW'(bus.out_valid), DW'(1'b0));
    chk("t6_rst_data",  bus.out_data, '0);
    step();
    chk("t6_rst_drop",  DW'(bus.out_valid), DW'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
